// File: rtl/census_hamming_cost.sv
`default_nettype none
// ============================================================================
// Module  : census_hamming_cost
// Brief   : Hamming matching cost between a left census code and the right
//           codes of the last DMAX columns. CENSUS_COST_MIN_EN adds a
//           winner-take-all argmin stage.
// Rev     : 1.0  initial release
// ============================================================================
module census_hamming_cost #(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int CODE_W = 8,
    parameter int DMAX   = 16,
    parameter int COST_W = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [CODE_W-1:0]          in_left,
    input  logic [CODE_W-1:0]          in_right,
    output logic                       out_valid,
    output logic [DMAX*COST_W-1:0]     out_cost,
    output logic [9:0]                 out_x,
    output logic [9:0]                 out_y,
    output logic                       out_sof,
    output logic                       out_eol
`ifdef CENSUS_COST_MIN_EN
    ,
    output logic [COST_W-1:0]          out_min_cost,
    output logic [$clog2(DMAX)-1:0]    out_min_disp
`endif
);
    localparam logic [9:0]        c_x_last   = 10'(IMG_W - 1);
    localparam logic [9:0]        c_y_last   = 10'(IMG_H - 1);
    localparam logic [COST_W-1:0] c_cost_max = COST_W'(CODE_W);

    logic [9:0]                  x_q, x_d, y_q, y_d;
    // hist_q[k] holds right(x-1-k); disparity 0 reads in_right directly
    logic [DMAX-2:0][CODE_W-1:0] hist_q, hist_d;

    logic                        s1_valid_q, s1_valid_d;
    logic [DMAX-1:0][CODE_W-1:0] s1_xor_q, s1_xor_d;
    logic [DMAX-1:0]             s1_inv_q, s1_inv_d;
    logic [9:0]                  s1_x_q, s1_x_d, s1_y_q, s1_y_d;
    logic                        s1_sof_q, s1_sof_d, s1_eol_q, s1_eol_d;

    logic                        s2_valid_q, s2_valid_d;
    logic [DMAX*COST_W-1:0]      s2_cost_q, s2_cost_d;
    logic [9:0]                  s2_x_q, s2_x_d, s2_y_q, s2_y_d;
    logic                        s2_sof_q, s2_sof_d, s2_eol_q, s2_eol_d;

    always_comb begin : p_front
        x_d        = x_q;
        y_d        = y_q;
        hist_d     = hist_q;
        s1_valid_d = in_valid;
        s1_xor_d   = s1_xor_q;
        s1_inv_d   = s1_inv_q;
        s1_x_d     = s1_x_q;
        s1_y_d     = s1_y_q;
        s1_sof_d   = s1_sof_q;
        s1_eol_d   = s1_eol_q;
        if (in_valid) begin
            if (x_q == c_x_last) begin
                x_d = '0;
                y_d = (y_q == c_y_last) ? '0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
            hist_d[0] = in_right;
            for (int k = 1; k < DMAX - 1; k++) begin
                hist_d[k] = hist_q[k-1];
            end
            s1_xor_d[0] = in_left ^ in_right;
            s1_inv_d[0] = 1'b0;
            // Entries reaching back past column 0 belong to the previous row
            for (int d = 1; d < DMAX; d++) begin
                s1_xor_d[d] = in_left ^ hist_q[d-1];
                s1_inv_d[d] = (x_q < 10'(d));
            end
            s1_x_d   = x_q;
            s1_y_d   = y_q;
            s1_sof_d = (x_q == 10'd0) && (y_q == 10'd0);
            s1_eol_d = (x_q == c_x_last);
        end
    end

    always_comb begin : p_cost
        logic [COST_W-1:0] cnt;
        cnt        = '0;
        s2_valid_d = s1_valid_q;
        s2_cost_d  = s2_cost_q;
        s2_x_d     = s2_x_q;
        s2_y_d     = s2_y_q;
        s2_sof_d   = s2_sof_q;
        s2_eol_d   = s2_eol_q;
        if (s1_valid_q) begin
            for (int d = 0; d < DMAX; d++) begin
                cnt = '0;
                for (int b = 0; b < CODE_W; b++) begin
                    cnt = cnt + COST_W'(s1_xor_q[d][b]);
                end
                s2_cost_d[d*COST_W +: COST_W] = s1_inv_q[d] ? c_cost_max : cnt;
            end
            s2_x_d   = s1_x_q;
            s2_y_d   = s1_y_q;
            s2_sof_d = s1_sof_q;
            s2_eol_d = s1_eol_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q        <= '0;
            y_q        <= '0;
            hist_q     <= '0;
            s1_valid_q <= 1'b0;
            s1_xor_q   <= '0;
            s1_inv_q   <= '0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            s1_sof_q   <= 1'b0;
            s1_eol_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_cost_q  <= '0;
            s2_x_q     <= '0;
            s2_y_q     <= '0;
            s2_sof_q   <= 1'b0;
            s2_eol_q   <= 1'b0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            hist_q     <= hist_d;
            s1_valid_q <= s1_valid_d;
            s1_xor_q   <= s1_xor_d;
            s1_inv_q   <= s1_inv_d;
            s1_x_q     <= s1_x_d;
            s1_y_q     <= s1_y_d;
            s1_sof_q   <= s1_sof_d;
            s1_eol_q   <= s1_eol_d;
            s2_valid_q <= s2_valid_d;
            s2_cost_q  <= s2_cost_d;
            s2_x_q     <= s2_x_d;
            s2_y_q     <= s2_y_d;
            s2_sof_q   <= s2_sof_d;
            s2_eol_q   <= s2_eol_d;
        end
    end

`ifdef CENSUS_COST_MIN_EN
    localparam int c_disp_w = $clog2(DMAX);

    logic                     s3_valid_q, s3_valid_d;
    logic [DMAX*COST_W-1:0]   s3_cost_q, s3_cost_d;
    logic [9:0]               s3_x_q, s3_x_d, s3_y_q, s3_y_d;
    logic                     s3_sof_q, s3_sof_d, s3_eol_q, s3_eol_d;
    logic [COST_W-1:0]        s3_min_q, s3_min_d;
    logic [c_disp_w-1:0]      s3_disp_q, s3_disp_d;

    // Strict less-than keeps the lowest disparity on ties
    always_comb begin : p_wta
        logic [COST_W-1:0]   best_c;
        logic [c_disp_w-1:0] best_d;
        best_c     = s2_cost_q[COST_W-1:0];
        best_d     = '0;
        for (int d = 1; d < DMAX; d++) begin
            if (s2_cost_q[d*COST_W +: COST_W] < best_c) begin
                best_c = s2_cost_q[d*COST_W +: COST_W];
                best_d = c_disp_w'(d);
            end
        end
        s3_valid_d = s2_valid_q;
        s3_cost_d  = s3_cost_q;
        s3_x_d     = s3_x_q;
        s3_y_d     = s3_y_q;
        s3_sof_d   = s3_sof_q;
        s3_eol_d   = s3_eol_q;
        s3_min_d   = s3_min_q;
        s3_disp_d  = s3_disp_q;
        if (s2_valid_q) begin
            s3_cost_d = s2_cost_q;
            s3_x_d    = s2_x_q;
            s3_y_d    = s2_y_q;
            s3_sof_d  = s2_sof_q;
            s3_eol_d  = s2_eol_q;
            s3_min_d  = best_c;
            s3_disp_d = best_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s3_valid_q <= 1'b0;
            s3_cost_q  <= '0;
            s3_x_q     <= '0;
            s3_y_q     <= '0;
            s3_sof_q   <= 1'b0;
            s3_eol_q   <= 1'b0;
            s3_min_q   <= '0;
            s3_disp_q  <= '0;
        end else begin
            s3_valid_q <= s3_valid_d;
            s3_cost_q  <= s3_cost_d;
            s3_x_q     <= s3_x_d;
            s3_y_q     <= s3_y_d;
            s3_sof_q   <= s3_sof_d;
            s3_eol_q   <= s3_eol_d;
            s3_min_q   <= s3_min_d;
            s3_disp_q  <= s3_disp_d;
        end
    end

    assign out_valid    = s3_valid_q;
    assign out_cost     = s3_cost_q;
    assign out_x        = s3_x_q;
    assign out_y        = s3_y_q;
    assign out_sof      = s3_sof_q;
    assign out_eol      = s3_eol_q;
    assign out_min_cost = s3_min_q;
    assign out_min_disp = s3_disp_q;
`else
    assign out_valid = s2_valid_q;
    assign out_cost  = s2_cost_q;
    assign out_x     = s2_x_q;
    assign out_y     = s2_y_q;
    assign out_sof   = s2_sof_q;
    assign out_eol   = s2_eol_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_census_hamming_cost.sv
`default_nettype none
// ============================================================================
// Module  : tb_census_hamming_cost
// Brief   : Self-checking bench: directed tables plus random traffic against a
//           column-indexed reference model; a second small-frame instance
//           exercises frame wrap. Honours CENSUS_COST_MIN_EN.
// Rev     : 1.0  initial release
// ============================================================================
module tb_census_hamming_cost;
    localparam int IMG_W  = 640;
    localparam int IMG_H  = 480;
    localparam int CODE_W = 8;
    localparam int DMAX   = 16;
    localparam int SW     = 8;
    localparam int SH     = 3;
`ifdef CENSUS_COST_MIN_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    typedef struct packed {
        logic        v;
        logic [63:0] cost;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        sof;
        logic        eol;
        logic [3:0]  minc;
        logic [3:0]  mind;
    } exp_t;

    typedef struct packed {
        logic [7:0] l;
        logic [7:0] r;
        logic [3:0] c0;
        logic [3:0] c1;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_left;
    logic [7:0]  in_right;

    logic        w_a_valid, w_b_valid;
    logic [63:0] w_a_cost, w_b_cost;
    logic [9:0]  w_a_x, w_a_y, w_b_x, w_b_y;
    logic        w_a_sof, w_a_eol, w_b_sof, w_b_eol;
    logic [3:0]  w_a_minc, w_a_mind, w_b_minc, w_b_mind;

    int          n_checks = 0;
    int          n_fail   = 0;

    int          mx [2];
    int          my [2];
    logic [7:0]  rrow [2][IMG_W];
    exp_t        q0 [$];
    exp_t        q1 [$];
    exp_t        held [2];

    census_hamming_cost u_dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_left      (in_left),
        .in_right     (in_right),
        .out_valid    (w_a_valid),
        .out_cost     (w_a_cost),
        .out_x        (w_a_x),
        .out_y        (w_a_y),
        .out_sof      (w_a_sof),
        .out_eol      (w_a_eol)
`ifdef CENSUS_COST_MIN_EN
        ,
        .out_min_cost (w_a_minc),
        .out_min_disp (w_a_mind)
`endif
    );

    census_hamming_cost #(.IMG_W(SW), .IMG_H(SH)) u_small (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_left      (in_left),
        .in_right     (in_right),
        .out_valid    (w_b_valid),
        .out_cost     (w_b_cost),
        .out_x        (w_b_x),
        .out_y        (w_b_y),
        .out_sof      (w_b_sof),
        .out_eol      (w_b_eol)
`ifdef CENSUS_COST_MIN_EN
        ,
        .out_min_cost (w_b_minc),
        .out_min_disp (w_b_mind)
`endif
    );

`ifndef CENSUS_COST_MIN_EN
    assign w_a_minc = 4'd0;
    assign w_a_mind = 4'd0;
    assign w_b_minc = 4'd0;
    assign w_b_mind = 4'd0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mx[i]   = 0;
            my[i]   = 0;
            held[i] = '0;
        end
        q0.delete();
        q1.delete();
    endtask

    // Reference: per-row array of right codes indexed by column
    function automatic exp_t model_beat(input int inst, input logic v,
                                        input logic [7:0] l, input logic [7:0] r);
        exp_t e;
        int   w, h, c, best;
        e = '0;
        if (!v) return e;
        w    = (inst == 1) ? SW : IMG_W;
        h    = (inst == 1) ? SH : IMG_H;
        e.v  = 1'b1;
        rrow[inst][mx[inst]] = r;
        e.x   = 10'(mx[inst]);
        e.y   = 10'(my[inst]);
        e.sof = (mx[inst] == 0) && (my[inst] == 0);
        e.eol = (mx[inst] == w - 1);
        best  = 1000;
        for (int d = 0; d < DMAX; d++) begin
            c = (mx[inst] < d) ? CODE_W : $countones(l ^ rrow[inst][mx[inst] - d]);
            e.cost[d*4 +: 4] = 4'(c);
            if (c < best) begin
                best   = c;
                e.minc = 4'(c);
                e.mind = 4'(d);
            end
        end
        if (mx[inst] == w - 1) begin
            mx[inst] = 0;
            my[inst] = (my[inst] == h - 1) ? 0 : my[inst] + 1;
        end else begin
            mx[inst] = mx[inst] + 1;
        end
        return e;
    endfunction

    task automatic check_out(input int inst, input exp_t e, input logic in_rst,
                             input logic ov, input logic [63:0] oc,
                             input logic [9:0] ox, input logic [9:0] oy,
                             input logic os, input logic oe,
                             input logic [3:0] mc, input logic [3:0] md);
        exp_t h;
        chk($sformatf("valid[%0d]", inst), 64'(ov), 64'(e.v));
        if (e.v) begin
            held[inst] = e;
            chk($sformatf("cost[%0d]", inst), oc, e.cost);
`ifdef CENSUS_COST_MIN_EN
            chk($sformatf("min_cost[%0d]", inst), 64'(mc), 64'(e.minc));
            chk($sformatf("min_disp[%0d]", inst), 64'(md), 64'(e.mind));
`endif
        end else if (in_rst) begin
            chk($sformatf("rst_cost[%0d]", inst), oc, 64'd0);
            chk($sformatf("rst_min[%0d]", inst), 64'({mc, md}), 64'd0);
        end
        h = held[inst];
        chk($sformatf("x[%0d]", inst), 64'(ox), 64'(h.x));
        chk($sformatf("y[%0d]", inst), 64'(oy), 64'(h.y));
        chk($sformatf("sof_eol[%0d]", inst), 64'({os, oe}), 64'({h.sof, h.eol}));
    endtask

    task automatic step(input logic r, input logic v, input logic [7:0] l, input logic [7:0] rr);
        exp_t ea, eb;
        rst      = r;
        in_valid = v;
        in_left  = l;
        in_right = rr;
        if (r) begin
            model_reset();
        end else begin
            q0.push_back(model_beat(0, v, l, rr));
            q1.push_back(model_beat(1, v, l, rr));
        end
        @(posedge clk);
        #1;
        ea = '0;
        eb = '0;
        if (!r && q0.size() >= LAT) begin
            ea = q0.pop_front();
            eb = q1.pop_front();
        end
        check_out(0, ea, r, w_a_valid, w_a_cost, w_a_x, w_a_y, w_a_sof, w_a_eol, w_a_minc, w_a_mind);
        check_out(1, eb, r, w_b_valid, w_b_cost, w_b_x, w_b_y, w_b_sof, w_b_eol, w_b_minc, w_b_mind);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'($urandom), 8'($urandom));
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    initial begin
        vec_t       tbl [6];
        vec_t       wta [4];
        logic [7:0] px;
        int         j;
        int         stall_beats;

        tbl[0] = '{l: 8'hA5, r: 8'hA5, c0: 4'd0, c1: 4'd8};
        tbl[1] = '{l: 8'hFF, r: 8'h00, c0: 4'd8, c1: 4'd4};
        tbl[2] = '{l: 8'h0F, r: 8'hF0, c0: 4'd8, c1: 4'd4};
        tbl[3] = '{l: 8'h3C, r: 8'h3C, c0: 4'd0, c1: 4'd4};
        tbl[4] = '{l: 8'h01, r: 8'h80, c0: 4'd2, c1: 4'd5};
        tbl[5] = '{l: 8'h80, r: 8'hFF, c0: 4'd7, c1: 4'd0};

        rst      = 1'b1;
        in_valid = 1'b0;
        in_left  = 8'h00;
        in_right = 8'h00;
        model_reset();

        do_reset();

        // Directed row-start vectors: cost[0], cost[1] and column tag
        for (int i = 0; i < 6 + LAT - 1; i++) begin
            if (i < 6) step(1'b0, 1'b1, tbl[i].l, tbl[i].r);
            else       step(1'b0, 1'b0, 8'h00, 8'h00);
            j = i - LAT + 1;
            if (j >= 0 && j < 6) begin
                chk("tbl_valid", 64'(w_a_valid), 64'd1);
                chk("tbl_c0", 64'(w_a_cost[3:0]), 64'(tbl[j].c0));
                chk("tbl_c1", 64'(w_a_cost[7:4]), 64'(tbl[j].c1));
                chk("tbl_x", 64'(w_a_x), 64'(j));
            end
        end

`ifdef CENSUS_COST_MIN_EN
        // Costs {5,3,3,7,8,...} at x=3: argmin 3 at disparity 1
        do_reset();
        wta[0] = '{l: 8'h00, r: 8'h7F, c0: 4'd0, c1: 4'd0};
        wta[1] = '{l: 8'h00, r: 8'h07, c0: 4'd0, c1: 4'd0};
        wta[2] = '{l: 8'h00, r: 8'h07, c0: 4'd0, c1: 4'd0};
        wta[3] = '{l: 8'h00, r: 8'h1F, c0: 4'd0, c1: 4'd0};
        for (int i = 0; i < 4 + LAT - 1; i++) begin
            if (i < 4) step(1'b0, 1'b1, wta[i].l, wta[i].r);
            else       step(1'b0, 1'b0, 8'h00, 8'h00);
            if (i == 3 + LAT - 1) begin
                chk("wta_cost", 64'(w_a_cost[15:0]), 64'h7335);
                chk("wta_min_cost", 64'(w_a_minc), 64'd3);
                chk("wta_min_disp", 64'(w_a_mind), 64'd1);
                chk("wta_x", 64'(w_a_x), 64'd3);
            end
        end
`else
        wta[0] = '0;
        wta[1] = '0;
        wta[2] = '0;
        wta[3] = '0;
`endif

        // Identical codes
        do_reset();
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1, wta[0].l ^ 8'hA5, 8'hA5);
        for (int i = 0; i < LAT; i++) step(1'b0, 1'b0, 8'h00, 8'h00);

        // Full row of maximally different codes, into the next row
        do_reset();
        for (int i = 0; i < IMG_W + 20; i++) step(1'b0, 1'b1, 8'hFF, 8'h00);
        for (int i = 0; i < LAT; i++) step(1'b0, 1'b0, 8'h00, 8'h00);

        // Left image shifted by three columns
        do_reset();
        for (int i = 0; i < IMG_W + 60; i++) begin
            px = 8'(i);
            step(1'b0, 1'b1, px - 8'd3, px);
        end
        for (int i = 0; i < LAT; i++) step(1'b0, 1'b0, 8'h00, 8'h00);

        // Stall pattern 1,0,0,1: two beats per group, each with fixed latency
        do_reset();
        stall_beats = 0;
        for (int g = 0; g < 40; g++) begin
            for (int k = 0; k < 4; k++) begin
                step(1'b0, (k == 0 || k == 3), 8'($urandom), 8'($urandom));
                if (w_a_valid) stall_beats++;
            end
        end
        for (int i = 0; i < LAT; i++) begin
            step(1'b0, 1'b0, 8'h00, 8'h00);
            if (w_a_valid) stall_beats++;
        end
        chk("stall_beats", 64'(stall_beats), 64'd80);

        // Random traffic with occasional mid-frame reset
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 499) == 0)
                step(1'b1, 1'b1, 8'($urandom), 8'($urandom));
            else
                step(1'b0, ($urandom_range(0, 9) < 7), 8'($urandom), 8'($urandom));
        end
        for (int i = 0; i < LAT; i++) step(1'b0, 1'b0, 8'h00, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
